// File: rtl/ras_pkg.sv
// Shared types and sizing helpers for the return-address-stack controller.
package ras_pkg;

    typedef enum logic {
        RAS_IDLE   = 1'b0,
        RAS_REFILL = 1'b1
    } ras_state_e;

    // Live-entry capacity: one top register on top of the BRAM entries.
    function automatic int ras_capacity(input int depth);
        return depth + 1;
    endfunction

    localparam int RAS_DEFAULT_DEPTH = 1024;
    localparam int RAS_DEFAULT_CAP   = ras_capacity(RAS_DEFAULT_DEPTH);

endpackage

// File: rtl/ras_ctrl_if.sv
// Push/pop request bundle between the branch predictor front end and ras_ctrl.
interface ras_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 10
);
    logic             flush_i;
    logic             push_i;
    logic             pop_i;
    logic [WIDTH-1:0] push_data_i;
    logic             ready_o;
    logic [WIDTH-1:0] top_o;
    logic             top_valid_o;
    logic             empty_o;
    logic [ADDR:0]    count_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output flush_i, push_i, pop_i, push_data_i,
        input  ready_o, top_o, top_valid_o, empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, push_data_i,
        output ready_o, top_o, top_valid_o, empty_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/bram.sv
// Simple dual-port block RAM with registered reads; OFS rotates every address,
// INCR is a constant added to read data (both 0 for a plain memory).
module bram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int ADDR  = 10,
    parameter int OFS   = 0,
    parameter int INCR  = 0
) (
    input  logic             clk,
    input  logic             rsta,
    input  logic             rea,
    input  logic             wea,
    input  logic [ADDR-1:0]  raddra,
    input  logic [ADDR-1:0]  waddra,
    input  logic [WIDTH-1:0] wia,
    output logic [WIDTH-1:0] doa,
    input  logic             rstb,
    input  logic             reb,
    input  logic             web,
    input  logic [ADDR-1:0]  raddrb,
    input  logic [ADDR-1:0]  waddrb,
    input  logic [WIDTH-1:0] wib,
    output logic [WIDTH-1:0] dob
);
    localparam logic [ADDR-1:0]  ADDR_OFS = ADDR'(OFS);
    localparam logic [WIDTH-1:0] DATA_INC = WIDTH'(INCR);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_doa;
    logic [WIDTH-1:0] r_dob;

    logic [ADDR-1:0] w_ra_a;
    logic [ADDR-1:0] w_wa_a;
    logic [ADDR-1:0] w_ra_b;
    logic [ADDR-1:0] w_wa_b;

    assign w_ra_a = raddra + ADDR_OFS;
    assign w_wa_a = waddra + ADDR_OFS;
    assign w_ra_b = raddrb + ADDR_OFS;
    assign w_wa_b = waddrb + ADDR_OFS;

    // Both write ports in one process so the array has a single driver.
    always_ff @(posedge clk) begin
        if (wea) begin
            r_mem[w_wa_a] <= wia;
        end
        if (web) begin
            r_mem[w_wa_b] <= wib;
        end
    end

    always_ff @(posedge clk) begin
        if (rsta) begin
            r_doa <= '0;
        end else if (rea) begin
            r_doa <= r_mem[w_ra_a] + DATA_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            r_dob <= '0;
        end else if (reb) begin
            r_dob <= r_mem[w_ra_b] + DATA_INC;
        end
    end

    assign doa = r_doa;
    assign dob = r_dob;
endmodule

// File: rtl/ras_ctrl.sv
// Return-address stack: top entry in a register, older entries in a circular
// BRAM buffer; a deep pop stalls one cycle while the top is refilled.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ADDR  = 10,
    parameter int DEPTH = 1024
) (
    input  logic       clk,
    input  logic       rst,
    ras_ctrl_if.slave  bus
);
    localparam int              CAP     = ras_capacity(DEPTH);
    localparam logic [ADDR:0]   CNT_CAP = (ADDR+1)'(CAP);
    localparam logic [ADDR:0]   CNT_ONE = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] SP_ONE  = ADDR'(1);

    ras_state_e       r_state;
    logic [ADDR-1:0]  r_sp;
    logic [ADDR:0]    r_count;
    logic [WIDTH-1:0] r_top;
    logic             r_ovf;
    logic             r_unf;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_clear;
    logic             w_wea;
    logic             w_reb;
    logic [ADDR-1:0]  w_raddrb;
    logic [WIDTH-1:0] w_dob;
    logic [WIDTH-1:0] w_doa_unused;

    assign w_ready  = (r_state == RAS_IDLE);
    assign w_push   = bus.push_i && w_ready;
    assign w_pop    = bus.pop_i && w_ready;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_CAP);
    assign w_clear  = rst || bus.flush_i;
    assign w_raddrb = r_sp - SP_ONE;

    // Only a pure push onto a live top spills it; only a deep pure pop reads back.
    assign w_wea = w_push && !w_pop && !w_empty && !w_clear;
    assign w_reb = w_pop && !w_push && (r_count > CNT_ONE) && !w_clear;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= RAS_IDLE;
            r_sp    <= '0;
            r_count <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            case (r_state)
                RAS_IDLE: begin
                    if (w_push) begin
                        r_top <= bus.push_data_i;
                        if (w_empty) begin
                            r_count <= CNT_ONE;
                        end else if (!w_pop) begin
                            r_sp <= r_sp + SP_ONE;
                            if (w_full) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_count <= r_count + CNT_ONE;
                            end
                        end
                    end else if (w_pop) begin
                        if (w_empty) begin
                            r_unf <= 1'b1;
                        end else if (r_count == CNT_ONE) begin
                            r_count <= '0;
                        end else begin
                            r_sp    <= r_sp - SP_ONE;
                            r_count <= r_count - CNT_ONE;
                            r_state <= RAS_REFILL;
                        end
                    end
                end
                RAS_REFILL: begin
                    r_top   <= w_dob;
                    r_state <= RAS_IDLE;
                end
                default: r_state <= RAS_IDLE;
            endcase
        end
    end

    bram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR),
        .OFS   (0),
        .INCR  (0)
    ) u_bram (
        .clk    (clk),
        .rsta   (1'b0),
        .rea    (1'b0),
        .wea    (w_wea),
        .raddra ('0),
        .waddra (r_sp),
        .wia    (r_top),
        .doa    (w_doa_unused),
        .rstb   (1'b0),
        .reb    (w_reb),
        .web    (1'b0),
        .raddrb (w_raddrb),
        .waddrb ('0),
        .wib    ('0),
        .dob    (w_dob)
    );

    assign bus.ready_o     = w_ready;
    assign bus.top_o       = r_top;
    assign bus.top_valid_o = w_ready && !w_empty;
    assign bus.empty_o     = w_empty;
    assign bus.count_o     = r_count;
    assign bus.overflow_o  = r_ovf;
    assign bus.underflow_o = r_unf;
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed scoreboard bench for ras_ctrl with a 4-entry BRAM (capacity 5).
module tb_ras_ctrl;
    localparam int W = 32;
    localparam int A = 2;
    localparam int D = 4;

    typedef struct {
        int          tgt;
        logic        rdy;
        logic [W-1:0] top;
        logic        tv;
        logic        em;
        logic [A:0]  cnt;
        logic        ov;
        logic        un;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    ras_ctrl_if #(.WIDTH(W), .ADDR(A)) bus ();

    ras_ctrl #(.WIDTH(W), .ADDR(A), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_vec = n_vec + 1;
            if (bus.ready_o !== e.rdy || bus.top_o !== e.top || bus.top_valid_o !== e.tv ||
                bus.empty_o !== e.em || bus.count_o !== e.cnt || bus.overflow_o !== e.ov ||
                bus.underflow_o !== e.un) begin
                n_bad = n_bad + 1;
                $display("FAIL vec%0d cyc%0d got rdy=%b top=%h tv=%b em=%b cnt=%0d ov=%b un=%b want rdy=%b top=%h tv=%b em=%b cnt=%0d ov=%b un=%b",
                         n_vec, cyc, bus.ready_o, bus.top_o, bus.top_valid_o, bus.empty_o,
                         bus.count_o, bus.overflow_o, bus.underflow_o,
                         e.rdy, e.top, e.tv, e.em, e.cnt, e.ov, e.un);
            end else begin
                $display("vec%0d cyc%0d ok top=%h cnt=%0d rdy=%b", n_vec, cyc, e.top, e.cnt, e.rdy);
            end
        end
    end

    task automatic expect_at(input int tgt, input logic rdy, input logic [W-1:0] top,
                             input logic tv, input logic em, input int cnt,
                             input logic ov, input logic un);
        exp_t e;
        e.tgt = tgt; e.rdy = rdy; e.top = top; e.tv = tv; e.em = em;
        e.cnt = (A+1)'(cnt); e.ov = ov; e.un = un;
        sb.push_back(e);
    endtask

    // One cycle of stimulus; the expectation is for the cycle after the edge.
    task automatic t(input logic p, input logic q, input logic f, input logic [W-1:0] d,
                     input logic rdy, input logic [W-1:0] top, input logic tv, input logic em,
                     input int cnt, input logic ov, input logic un);
        bus.push_i = p; bus.pop_i = q; bus.flush_i = f; bus.push_data_i = d;
        expect_at(cyc + 1, rdy, top, tv, em, cnt, ov, un);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.push_i = 0; bus.pop_i = 0; bus.flush_i = 0; bus.push_data_i = '0;
        @(posedge clk); @(posedge clk); #1;
        expect_at(cyc, 1, 0, 0, 1, 0, 0, 0);
        rst = 0;

        //  p q f data        rdy top         tv em cnt ov un
        t(1,0,0,32'h100,      1, 32'h100,     1, 0, 1, 0, 0);
        t(1,0,0,32'h200,      1, 32'h200,     1, 0, 2, 0, 0);
        t(1,0,0,32'h300,      1, 32'h300,     1, 0, 3, 0, 0);
        t(0,1,0,0,            0, 32'h300,     0, 0, 2, 0, 0);
        t(0,0,0,0,            1, 32'h200,     1, 0, 2, 0, 0);
        // push during refill is dropped
        t(1,0,0,32'h400,      1, 32'h400,     1, 0, 3, 0, 0);
        t(0,1,0,0,            0, 32'h400,     0, 0, 2, 0, 0);
        t(1,0,0,32'h999,      1, 32'h200,     1, 0, 2, 0, 0);
        t(0,0,0,0,            1, 32'h200,     1, 0, 2, 0, 0);
        // replace, then pop returns the untouched lower entry
        t(1,1,0,32'hABC,      1, 32'hABC,     1, 0, 2, 0, 0);
        t(0,1,0,0,            0, 32'hABC,     0, 0, 1, 0, 0);
        t(0,0,0,0,            1, 32'h100,     1, 0, 1, 0, 0);
        t(0,1,0,0,            1, 32'h100,     0, 1, 0, 0, 0);
        // underflow and replace-on-empty
        t(0,1,0,0,            1, 32'h100,     0, 1, 0, 0, 1);
        t(0,0,0,0,            1, 32'h100,     0, 1, 0, 0, 0);
        t(1,1,0,32'h44,       1, 32'h44,      1, 0, 1, 0, 0);
        t(0,1,0,0,            1, 32'h44,      0, 1, 0, 0, 0);
        // fill past capacity; value 1 is lost
        t(1,0,0,32'd1,        1, 32'd1,       1, 0, 1, 0, 0);
        t(1,0,0,32'd2,        1, 32'd2,       1, 0, 2, 0, 0);
        t(1,0,0,32'd3,        1, 32'd3,       1, 0, 3, 0, 0);
        t(1,0,0,32'd4,        1, 32'd4,       1, 0, 4, 0, 0);
        t(1,0,0,32'd5,        1, 32'd5,       1, 0, 5, 0, 0);
        t(1,0,0,32'd6,        1, 32'd6,       1, 0, 5, 1, 0);
        t(0,1,0,0,            0, 32'd6,       0, 0, 4, 0, 0);
        t(0,0,0,0,            1, 32'd5,       1, 0, 4, 0, 0);
        t(0,1,0,0,            0, 32'd5,       0, 0, 3, 0, 0);
        t(0,0,0,0,            1, 32'd4,       1, 0, 3, 0, 0);
        t(0,1,0,0,            0, 32'd4,       0, 0, 2, 0, 0);
        t(0,0,0,0,            1, 32'd3,       1, 0, 2, 0, 0);
        t(0,1,0,0,            0, 32'd3,       0, 0, 1, 0, 0);
        t(0,0,0,0,            1, 32'd2,       1, 0, 1, 0, 0);
        t(0,1,0,0,            1, 32'd2,       0, 1, 0, 0, 0);
        t(0,1,0,0,            1, 32'd2,       0, 1, 0, 0, 1);
        // flush during refill
        t(1,0,0,32'h10,       1, 32'h10,      1, 0, 1, 0, 0);
        t(1,0,0,32'h20,       1, 32'h20,      1, 0, 2, 0, 0);
        t(1,0,0,32'h30,       1, 32'h30,      1, 0, 3, 0, 0);
        t(0,1,0,0,            0, 32'h30,      0, 0, 2, 0, 0);
        t(0,0,1,0,            1, 32'h0,       0, 1, 0, 0, 0);
        t(1,0,0,32'h7,        1, 32'h7,       1, 0, 1, 0, 0);
        t(0,0,0,0,            1, 32'h7,       1, 0, 1, 0, 0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            n_bad = n_bad + sb.size();
            $display("FAIL drain %0d expectations never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
